// File: rtl/vcve2_vrf_mem_adapter.sv
// Serialises whole-vector-register read/write requests into PORT_W-wide beats on a
// single-port word memory. Writes are tail-undisturbed via vl/vsew-derived byte enables.
module vcve2_vrf_mem_adapter #(
  parameter int unsigned VLEN   = 128,
  parameter int unsigned PORT_W = 32,
  localparam int unsigned NBEATS = VLEN / PORT_W,
  localparam int unsigned BEAT_W = $clog2(NBEATS),
  localparam int unsigned VL_W   = $clog2(VLEN / 8) + 1,
  localparam int unsigned BYTES  = PORT_W / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic                  we_i,
  input  logic [4:0]            vaddr_i,
  input  logic [VLEN-1:0]       wdata_i,
  input  logic [VL_W-1:0]       vl_i,
  input  logic [2:0]            vsew_i,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [VLEN-1:0]       rdata_o,
  output logic                  err_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [5+BEAT_W-1:0]   mem_addr_o,
  output logic [BYTES-1:0]      mem_be_o,
  output logic [PORT_W-1:0]     mem_wdata_o,
  input  logic [PORT_W-1:0]     mem_rdata_i
);

  typedef enum logic [2:0] {StIdle, StRd, StRdWait, StWr, StResp} state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [BEAT_W-1:0]   beat_prev;
  logic [4:0]          vaddr_q, vaddr_d;
  logic [VLEN-1:0]     wdata_q, wdata_d;
  logic [VL_W-1:0]     vl_q, vl_d;
  logic [2:0]          vsew_q, vsew_d;
  logic                err_q, err_d;
  logic [VLEN-1:0]     buf_q, buf_d;
  logic [BYTES-1:0]    wr_be;
  logic [31:0]         gidx;
  logic                last_beat;

  assign beat_prev = beat_q - 1'b1;
  assign last_beat = (beat_q == BEAT_W'(NBEATS - 1));

  // Byte b of the register is live iff its element index (b >> vsew) is below vl.
  always_comb begin
    wr_be = '0;
    gidx  = '0;
    for (int i = 0; i < BYTES; i++) begin
      gidx     = 32'(beat_q) * BYTES + 32'(i);
      wr_be[i] = (gidx >> vsew_q) < 32'(vl_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    vaddr_d     = vaddr_q;
    wdata_d     = wdata_q;
    vl_d        = vl_q;
    vsew_d      = vsew_q;
    err_d       = err_q;
    buf_d       = buf_q;
    gnt_o       = 1'b0;
    rvalid_o    = 1'b0;
    rdata_o     = '0;
    err_o       = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;

    unique case (state_q)
      StIdle: begin
        gnt_o = 1'b1;
        if (req_i) begin
          vaddr_d = vaddr_i;
          wdata_d = wdata_i;
          vl_d    = vl_i;
          vsew_d  = vsew_i;
          beat_d  = '0;
          buf_d   = '0;
          err_d   = 1'b0;
          if (vsew_i > 3'b010) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            state_d = we_i ? StWr : StRd;
          end
        end
      end
      StRd: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {vaddr_q, beat_q};
        mem_be_o   = '1;
        // Memory returns data one cycle after the strobe, so capture the previous beat.
        if (beat_q != '0) begin
          buf_d[32'(beat_prev) * PORT_W +: PORT_W] = mem_rdata_i;
        end
        beat_d = beat_q + 1'b1;
        if (last_beat) begin
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        buf_d[(NBEATS - 1) * PORT_W +: PORT_W] = mem_rdata_i;
        state_d = StResp;
      end
      StWr: begin
        mem_req_o   = |wr_be;
        mem_we_o    = |wr_be;
        mem_addr_o  = {vaddr_q, beat_q};
        mem_be_o    = wr_be;
        mem_wdata_o = wdata_q[32'(beat_q) * PORT_W +: PORT_W];
        beat_d      = beat_q + 1'b1;
        if (last_beat) begin
          state_d = StResp;
        end
      end
      StResp: begin
        rvalid_o = 1'b1;
        rdata_o  = buf_q;
        err_o    = err_q;
        if (rready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      beat_q  <= '0;
      vaddr_q <= '0;
      wdata_q <= '0;
      vl_q    <= '0;
      vsew_q  <= '0;
      err_q   <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      vaddr_q <= vaddr_d;
      wdata_q <= wdata_d;
      vl_q    <= vl_d;
      vsew_q  <= vsew_d;
      err_q   <= err_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_vcve2_vrf_mem_adapter.sv
// Scoreboard bench for vcve2_vrf_mem_adapter: stimulus queues expected strobes and
// responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_vcve2_vrf_mem_adapter;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         req_i;
  logic         gnt_o;
  logic         we_i;
  logic [4:0]   vaddr_i;
  logic [127:0] wdata_i;
  logic [4:0]   vl_i;
  logic [2:0]   vsew_i;
  logic         rvalid_o;
  logic         rready_i;
  logic [127:0] rdata_o;
  logic         err_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [6:0]   mem_addr_o;
  logic [3:0]   mem_be_o;
  logic [31:0]  mem_wdata_o;
  logic [31:0]  mem_rdata_i;

  vcve2_vrf_mem_adapter dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .we_i        (we_i),
    .vaddr_i     (vaddr_i),
    .wdata_i     (wdata_i),
    .vl_i        (vl_i),
    .vsew_i      (vsew_i),
    .rvalid_o    (rvalid_o),
    .rready_i    (rready_i),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_be_o    (mem_be_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [6:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } strobe_t;

  typedef struct packed {
    logic [127:0] rdata;
    logic         err;
  } resp_t;

  strobe_t exp_mem_q[$];
  resp_t   exp_resp_q[$];
  int      n_tests = 0;
  int      n_fail  = 0;

  logic [31:0] mem [128];

  localparam logic [127:0] WPAT   = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
  localparam logic [127:0] RD_V3  = 128'h000000A3_000000A2_000000A1_000000A0;
  localparam logic [127:0] RD_V9  = 128'hDEAD0003_DEAD0002_DEAD5544_33221100;

  // Word memory with one-cycle read latency and byte-enabled writes.
  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int i = 0; i < 4; i++) begin
          if (mem_be_o[i]) mem[mem_addr_o][8*i +: 8] <= mem_wdata_o[8*i +: 8];
        end
      end else begin
        mem_rdata_i <= mem[mem_addr_o];
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    strobe_t s;
    resp_t   r;
    if (mem_req_o) begin
      if (exp_mem_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_strobe: got addr %0d we %0b, required no strobe",
                 mem_addr_o, mem_we_o);
      end else begin
        s = exp_mem_q.pop_front();
        check("strobe_we", 128'(mem_we_o), 128'(s.we));
        check("strobe_addr", 128'(mem_addr_o), 128'(s.addr));
        check("strobe_be", 128'(mem_be_o), 128'(s.be));
        if (s.we) check("strobe_wdata", 128'(mem_wdata_o), 128'(s.wdata));
      end
    end
    if (rvalid_o && rready_i) begin
      if (exp_resp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got rdata %h, required no response", rdata_o);
      end else begin
        r = exp_resp_q.pop_front();
        check("resp_rdata", rdata_o, r.rdata);
        check("resp_err", 128'(err_o), 128'(r.err));
      end
    end
  end

  task automatic push_strobe(input logic we, input int addr, input logic [3:0] be,
                             input logic [31:0] wd);
    strobe_t s;
    s.we = we; s.addr = 7'(addr); s.be = be; s.wdata = wd;
    exp_mem_q.push_back(s);
  endtask

  task automatic push_resp(input logic [127:0] rd, input logic err);
    resp_t r;
    r.rdata = rd; r.err = err;
    exp_resp_q.push_back(r);
  endtask

  // Issue one request, measure accept-to-rvalid latency, optionally stall rready.
  task automatic run_req(input string name, input logic we, input logic [4:0] va,
                         input logic [127:0] wd, input logic [4:0] vl, input logic [2:0] sew,
                         input int exp_lat, input int hold, input logic [127:0] exp_rd);
    int cyc;
    @(posedge clk); #1;
    req_i = 1'b1; we_i = we; vaddr_i = va; wdata_i = wd; vl_i = vl; vsew_i = sew;
    rready_i = (hold == 0);
    cyc = 0;
    @(negedge clk);
    while (!gnt_o && cyc < 20) begin cyc++; @(negedge clk); end
    check({name, "_gnt"}, 128'(gnt_o), 128'(1));
    @(posedge clk); #1;
    req_i = 1'b0;
    cyc = 1;
    @(negedge clk);
    while (!rvalid_o && cyc < 40) begin cyc++; @(negedge clk); end
    check({name, "_latency"}, 128'(cyc), 128'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      req_i = 1'b1; we_i = 1'b0; vaddr_i = 5'd1; vsew_i = 3'b000;
      @(negedge clk);
      check({name, "_hold_rvalid"}, 128'(rvalid_o), 128'(1));
      check({name, "_hold_rdata"}, rdata_o, exp_rd);
      check({name, "_hold_nognt"}, 128'(gnt_o), 128'(0));
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      req_i = 1'b0; rready_i = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    check({name, "_idle_gnt"}, 128'(gnt_o), 128'(1));
    check({name, "_idle_rvalid"}, 128'(rvalid_o), 128'(0));
    check({name, "_strobes_left"}, 128'(exp_mem_q.size()), 128'(0));
    check({name, "_resps_left"}, 128'(exp_resp_q.size()), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no end of run, required $finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    for (int k = 0; k < 4; k++) begin
      mem[12 + k] = 32'hA0 + 32'(k);
      mem[36 + k] = 32'hDEAD0000 + 32'(k);
    end
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; vaddr_i = '0; wdata_i = '0;
    vl_i = '0; vsew_i = '0; rready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_gnt", 128'(gnt_o), 128'(1));
    check("reset_rvalid", 128'(rvalid_o), 128'(0));
    check("reset_memreq", 128'(mem_req_o), 128'(0));
    check("reset_rdata", rdata_o, 128'(0));
    check("reset_err", 128'(err_o), 128'(0));
    @(posedge clk); #1;
    rst_i = 1'b0;

    // Read v3: addresses 12..15, rvalid at cycle 6.
    for (int k = 0; k < 4; k++) push_strobe(1'b0, 12 + k, 4'hF, 32'h0);
    push_resp(RD_V3, 1'b0);
    run_req("read_v3", 1'b0, 5'd3, '0, 5'd0, 3'b000, 6, 0, RD_V3);

    // Full write v7, SEW32, vl=4.
    push_strobe(1'b1, 28, 4'hF, 32'h33221100);
    push_strobe(1'b1, 29, 4'hF, 32'h77665544);
    push_strobe(1'b1, 30, 4'hF, 32'hBBAA9988);
    push_strobe(1'b1, 31, 4'hF, 32'hFFEEDDCC);
    push_resp('0, 1'b0);
    run_req("write_full", 1'b1, 5'd7, WPAT, 5'd4, 3'b010, 5, 0, '0);

    // Tail-undisturbed: SEW16, vl=3 -> bytes 0..5 only.
    push_strobe(1'b1, 36, 4'hF, 32'h33221100);
    push_strobe(1'b1, 37, 4'h3, 32'h77665544);
    push_resp('0, 1'b0);
    run_req("write_tail", 1'b1, 5'd9, WPAT, 5'd3, 3'b001, 5, 0, '0);

    // Read back v9 to confirm tail bytes kept their old contents.
    for (int k = 0; k < 4; k++) push_strobe(1'b0, 36 + k, 4'hF, 32'h0);
    push_resp(RD_V9, 1'b0);
    run_req("read_v9", 1'b0, 5'd9, '0, 5'd0, 3'b000, 6, 0, RD_V9);

    // vl=0: no strobes, response still returned.
    push_resp('0, 1'b0);
    run_req("write_vl0", 1'b1, 5'd2, WPAT, 5'd0, 3'b000, 5, 0, '0);

    // vl larger than element count enables every byte.
    push_strobe(1'b1, 20, 4'hF, 32'h33221100);
    push_strobe(1'b1, 21, 4'hF, 32'h77665544);
    push_strobe(1'b1, 22, 4'hF, 32'hBBAA9988);
    push_strobe(1'b1, 23, 4'hF, 32'hFFEEDDCC);
    push_resp('0, 1'b0);
    run_req("write_vlbig", 1'b1, 5'd5, WPAT, 5'd16, 3'b010, 5, 0, '0);

    // Illegal vsew: immediate error response.
    push_resp('0, 1'b1);
    run_req("bad_vsew", 1'b1, 5'd4, WPAT, 5'd4, 3'b011, 1, 0, '0);

    // Stall rready for 5 cycles in RESP.
    for (int k = 0; k < 4; k++) push_strobe(1'b0, 12 + k, 4'hF, 32'h0);
    push_resp(RD_V3, 1'b0);
    run_req("read_hold", 1'b0, 5'd3, '0, 5'd0, 3'b000, 6, 5, RD_V3);

    // Reset during beat 2 of a read.
    for (int k = 0; k < 3; k++) push_strobe(1'b0, 12 + k, 4'hF, 32'h0);
    @(posedge clk); #1;
    req_i = 1'b1; we_i = 1'b0; vaddr_i = 5'd3; vsew_i = 3'b000;
    @(posedge clk); #1;
    req_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_mid_memreq", 128'(mem_req_o), 128'(0));
    check("rst_mid_rvalid", 128'(rvalid_o), 128'(0));
    check("rst_mid_gnt", 128'(gnt_o), 128'(1));
    check("rst_mid_strobes_left", 128'(exp_mem_q.size()), 128'(0));

    for (int k = 0; k < 4; k++) push_strobe(1'b0, 12 + k, 4'hF, 32'h0);
    push_resp(RD_V3, 1'b0);
    run_req("read_after_rst", 1'b0, 5'd3, '0, 5'd0, 3'b000, 6, 0, RD_V3);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vcve2_vrf_mem_adapter.md
Name: vcve2_vrf_mem_adapter

Overview:
- Responder side of the vector register file access sequence. The VRF_READ*/VRF_WRITE controller issues whole-register requests of VLEN bits.
- This block services each request by serialising it into PORT_W-wide beats on a single-port word memory that holds the 32 vector registers.
- Writes are tail-undisturbed: byte enables are derived from vl and vsew, so bytes past vl are never written.
- Sits between the vector controller in ID/EX and the VRF storage macro.

Parameters:
- VLEN, 128, vector register length in bits; must be a multiple of PORT_W.
- PORT_W, 32, memory word width in bits.
- NBEATS, VLEN/PORT_W (derived localparam), beats per register.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_i  in  1  request valid.
- gnt_o  out  1  request accepted this cycle.
- we_i  in  1  1 = write register, 0 = read register.
- vaddr_i  in  5  vector register index.
- wdata_i  in  VLEN  write data; bit 0 is element 0.
- vl_i  in  $clog2(VLEN/8)+1  active element count.
- vsew_i  in  3  vsew_e encoding (VSEW_8/16/32).
- rvalid_o  out  1  response valid.
- rready_i  in  1  response consumed.
- rdata_o  out  VLEN  read data; 0 on write responses.
- err_o  out  1  response carries an error; valid with rvalid_o.
- mem_req_o  out  1  memory access strobe.
- mem_we_o  out  1  memory write.
- mem_addr_o  out  5+$clog2(NBEATS)  word address {vaddr, beat}.
- mem_be_o  out  PORT_W/8  byte enables.
- mem_wdata_o  out  PORT_W  memory write data.
- mem_rdata_i  in  PORT_W  memory read data; valid exactly 1 cycle after a read strobe; memory is always ready.

Behaviour:
- Reset: synchronous active-high on clk_i. All outputs 0 except gnt_o = 1. State = IDLE, beat counter = 0, data buffer cleared. Reset in any state aborts the operation immediately; no further mem_req_o is issued.
- State machine: IDLE, RD, RD_WAIT, WR, RESP.
- IDLE
  - gnt_o = 1; no other state drives gnt_o.
  - A cycle with req_i & gnt_o is an accept. On accept, latch we, vaddr, wdata, vl, vsew and clear the beat counter.
  - If vsew_i > 3'b010 (illegal encoding): go to RESP with err_o = 1 and issue no memory access.
  - Otherwise go to WR if we = 1, else RD.
- RD
  - mem_req_o = 1, mem_we_o = 0, mem_addr_o = {vaddr, beat}, mem_be_o = all 1.
  - Beat increments every cycle. Data of beat k is captured into buffer slice k in the following cycle.
  - After beat NBEATS-1 is issued, go to RD_WAIT.
- RD_WAIT: capture the last beat, go to RESP. Read latency is accept at cycle 0, first strobe at cycle 1, rvalid_o at cycle NBEATS+2 (6 at default parameters).
- WR
  - One beat per cycle. mem_wdata_o = wdata slice [beat*PORT_W +: PORT_W].
  - Byte b (global byte index) is enabled iff (b >> vsew) < vl, where vsew 0/1/2 means 1/2/4-byte elements.
  - A beat whose byte enables are all 0 is skipped: mem_req_o = 0 that cycle, but the beat counter still advances. Fixed latency: NBEATS cycles in WR.
  - After beat NBEATS-1, go to RESP.
  - vl = 0 produces no memory writes but still returns a response.
  - vl above VLEN/(8·SEW bytes) simply enables every byte.
- RESP
  - rvalid_o = 1 and held stable with rdata_o and err_o until rready_i.
  - On rvalid_o & rready_i, go to IDLE in the next cycle. The next request is accepted no earlier than that IDLE cycle; there is no back-to-back overlap.
  - rready_i asserted outside RESP is ignored.
- req_i asserted while not in IDLE is ignored (gnt_o = 0). The requester must hold the request until it is granted.

Test Plan:
- Read: memory word at address {v3, k} = 0xA0+k for k = 0..3. Request read of v3 -> 4 strobes at consecutive addresses 12..15, rvalid_o at cycle 6, rdata_o = 0x000000A3_000000A2_000000A1_000000A0, err_o = 0.
- Full write: v7 write, vsew = VSEW_32, vl = 4, wdata 0x11..FF pattern -> 4 strobes at addresses 28..31, mem_be_o = 0xF each, then a response with err_o = 0.
- Tail-undisturbed: vsew = VSEW_16, vl = 3 -> beat 0 be = 0xF, beat 1 be = 0x3, beats 2 and 3 have no mem_req_o; response at the same cycle count as a full write.
- Edge cases:
  - vl = 0 write -> zero strobes, response still returned.
  - vsew = 3'b011 -> err_o = 1 with rvalid_o at cycle 1, no strobe.
- Handshake: hold rready_i low for 5 cycles in RESP -> rvalid_o and rdata_o stable, a second req_i is not granted; assert rready_i -> gnt_o = 1 the next cycle.
- Reset mid-read at beat 2 -> next cycle mem_req_o = 0, rvalid_o = 0, gnt_o = 1; a fresh read then completes normally.
